// File: rtl/rgb_pwm_ctrl.sv
// Fabric controller for the iCE40UP RGB current-sink driver: register file, driver
// power-up sequencing, frame-synchronous 8-bit PWM on three channels and optional blink.
module rgb_pwm_ctrl #(
  parameter int unsigned WARM_CYCLES  = 4800,
  parameter logic [7:0]  PRESCALE_RST = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       rgb0_pwm,
  output logic       rgb1_pwm,
  output logic       rgb2_pwm,
  output logic       curren,
  output logic       rgbleden,
  output logic       ready
);

  localparam int WW = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WARM_LAST = WW'(WARM_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    ON,
    BLINK_OFF
  } state_e;

  state_e        state_q;
  logic [1:0]    ctrl_q;
  logic [7:0]    prescale_q;
  logic [7:0]    duty_q [3];
  logic [7:0]    dutyAct_q [3];
  logic [7:0]    onTime_q;
  logic [7:0]    offTime_q;
  logic [7:0]    presCnt_q;
  logic [7:0]    pwmCnt_q;
  logic [7:0]    blinkCnt_q;
  logic [WW-1:0] warmCnt_q;
  logic [2:0]    rgbPwm_q;
  logic          curren_q;
  logic          ready_q;

  logic tick_d;
  logic frameEnd_d;
  logic blinkActive_d;
  logic [8:0] blinkNext_d;

  assign tick_d        = (presCnt_q == prescale_q);
  assign frameEnd_d    = tick_d && (pwmCnt_q == 8'hFF);
  assign blinkActive_d = ctrl_q[1] && (onTime_q != 8'd0);
  assign blinkNext_d   = {1'b0, blinkCnt_q} + 9'd1;

  // Host register file; address 7 is reserved and silently dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= 2'b00;
      prescale_q <= PRESCALE_RST;
      onTime_q   <= 8'd0;
      offTime_q  <= 8'd0;
      for (int i = 0; i < 3; i++) duty_q[i] <= 8'd0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0:    ctrl_q     <= wr_data[1:0];
        3'd1:    prescale_q <= wr_data;
        3'd2:    duty_q[0]  <= wr_data;
        3'd3:    duty_q[1]  <= wr_data;
        3'd4:    duty_q[2]  <= wr_data;
        3'd5:    onTime_q   <= wr_data;
        3'd6:    offTime_q  <= wr_data;
        default: ;
      endcase
    end
  end

  // Sequencer; every output is registered here so the driver never sees a glitch.
  always_ff @(posedge clk) begin
    if (rst || !ctrl_q[0]) begin
      state_q    <= IDLE;
      presCnt_q  <= 8'd0;
      pwmCnt_q   <= 8'd0;
      blinkCnt_q <= 8'd0;
      warmCnt_q  <= '0;
      rgbPwm_q   <= 3'b000;
      curren_q   <= 1'b0;
      ready_q    <= 1'b0;
      if (rst) begin
        for (int i = 0; i < 3; i++) dutyAct_q[i] <= 8'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= WARMUP;
          warmCnt_q <= '0;
          curren_q  <= 1'b1;
          ready_q   <= 1'b0;
          rgbPwm_q  <= 3'b000;
        end
        WARMUP: begin
          rgbPwm_q <= 3'b000;
          curren_q <= 1'b1;
          if (warmCnt_q == WARM_LAST) begin
            state_q    <= ON;
            presCnt_q  <= 8'd0;
            pwmCnt_q   <= 8'd0;
            blinkCnt_q <= 8'd0;
            ready_q    <= 1'b1;
            for (int i = 0; i < 3; i++) dutyAct_q[i] <= duty_q[i];
          end else begin
            warmCnt_q <= warmCnt_q + 1'b1;
          end
        end
        ON, BLINK_OFF: begin
          curren_q <= 1'b1;
          ready_q  <= 1'b1;
          for (int i = 0; i < 3; i++) begin
            rgbPwm_q[i] <= (state_q == ON) && (pwmCnt_q < dutyAct_q[i]);
          end
          if (tick_d) begin
            presCnt_q <= 8'd0;
            pwmCnt_q  <= pwmCnt_q + 8'd1;
          end else begin
            presCnt_q <= presCnt_q + 8'd1;
          end
          // Shadow duty and blink frame counting only advance on frame boundaries.
          if (frameEnd_d) begin
            for (int i = 0; i < 3; i++) dutyAct_q[i] <= duty_q[i];
            if (state_q == ON) begin
              if (blinkActive_d) begin
                if (blinkNext_d >= {1'b0, onTime_q}) begin
                  state_q    <= BLINK_OFF;
                  blinkCnt_q <= 8'd0;
                end else begin
                  blinkCnt_q <= blinkNext_d[7:0];
                end
              end
            end else begin
              if (!ctrl_q[1] || (blinkNext_d >= {1'b0, offTime_q})) begin
                state_q    <= ON;
                blinkCnt_q <= 8'd0;
              end else begin
                blinkCnt_q <= blinkNext_d[7:0];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rgb0_pwm = rgbPwm_q[0];
  assign rgb1_pwm = rgbPwm_q[1];
  assign rgb2_pwm = rgbPwm_q[2];
  assign curren   = curren_q;
  assign rgbleden = curren_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl: directed warm-up/duty/blink/disable scenarios plus
// randomized sessions, each output cycle compared with a timeline model of the controller.
module tb_rgb_pwm_ctrl;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rgb0_pwm, rgb1_pwm, rgb2_pwm, curren, rgbleden, ready;

  rgb_pwm_ctrl #(.WARM_CYCLES(W), .PRESCALE_RST(8'd0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rgb0_pwm(rgb0_pwm), .rgb1_pwm(rgb1_pwm), .rgb2_pwm(rgb2_pwm),
    .curren(curren), .rgbleden(rgbleden), .ready(ready)
  );

  always #5 clk = ~clk;

  int edgeNum = 0;
  always @(posedge clk) edgeNum <= edgeNum + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int at;
    int ch;
    int val;
  } dutyWr_t;
  dutyWr_t dutyLog[$];

  int sessStart = -1;
  int sessStop  = -1;
  int sessPre, sessOn, sessOff;
  bit sessBlink;
  int mPre, mOn, mOff;
  int frameHigh[3][16];

  // Single comparison point; a mismatch is reported with the observed and required values.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h required=%0h at edge %0d", tag, observed, expected, edgeNum);
    end
  endtask

  // Active duty for a frame is whatever DUTYn held just before that frame's load edge.
  function automatic int dutyAt(input int ch, input int loadEdge);
    int v;
    v = 0;
    foreach (dutyLog[i]) begin
      if (dutyLog[i].ch == ch && dutyLog[i].at < loadEdge) v = dutyLog[i].val;
    end
    return v;
  endfunction

  // Expected {ready, curren, rgbleden, rgb2, rgb1, rgb0} right after posedge number t.
  function automatic logic [5:0] modelOutputs(input int t);
    int onEdge, m, cnt, f, period, loadEdge;
    bit onF;
    logic [2:0] rgb;
    if (sessStart < 0 || t <= sessStart) return 6'b000000;
    if (sessStop >= 0 && t > sessStop) return 6'b000000;
    onEdge = sessStart + W + 1;
    if (t < onEdge) return 6'b011000;
    if (t == onEdge) return 6'b111000;
    m = t - onEdge - 1;
    cnt = (m / (sessPre + 1)) % 256;
    f = m / (256 * (sessPre + 1));
    period = sessOn + ((sessOff == 0) ? 1 : sessOff);
    onF = !(sessBlink && sessOn != 0) || ((f % period) < sessOn);
    loadEdge = onEdge + f * 256 * (sessPre + 1);
    rgb = 3'b000;
    for (int ch = 0; ch < 3; ch++) rgb[ch] = onF && (cnt < dutyAt(ch, loadEdge));
    return {3'b111, rgb};
  endfunction

  task automatic stepCycle();
    logic [5:0] obs;
    int onEdge, m, f;
    @(negedge clk);
    obs = {ready, curren, rgbleden, rgb2_pwm, rgb1_pwm, rgb0_pwm};
    checkOutput("outputs", 32'(obs), 32'(modelOutputs(edgeNum)));
    if (sessStart >= 0 && (sessStop < 0 || edgeNum <= sessStop)) begin
      onEdge = sessStart + W + 1;
      if (edgeNum > onEdge) begin
        m = edgeNum - onEdge - 1;
        f = m / (256 * (sessPre + 1));
        if (f < 16) begin
          for (int ch = 0; ch < 3; ch++) frameHigh[ch][f] += int'(obs[ch]);
        end
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic runUntil(input int target);
    while (edgeNum < target) stepCycle();
  endtask

  // One-cycle register write; the model learns the edge at which the write lands.
  task automatic applyStimulus(input int addr, input int data);
    int landing;
    dutyWr_t w;
    landing = edgeNum + 1;
    wr_en   = 1'b1;
    wr_addr = addr[2:0];
    wr_data = data[7:0];
    case (addr)
      0: begin
        if (data[0] && (sessStart < 0 || sessStop >= 0)) begin
          sessStart = landing;
          sessStop  = -1;
          sessPre   = mPre;
          sessOn    = mOn;
          sessOff   = mOff;
          sessBlink = data[1];
          for (int c = 0; c < 3; c++) for (int k = 0; k < 16; k++) frameHigh[c][k] = 0;
        end else if (!data[0] && sessStart >= 0 && sessStop < 0) begin
          sessStop = landing;
        end
      end
      1: mPre = data & 255;
      2, 3, 4: begin
        w.at = landing;
        w.ch = addr - 2;
        w.val = data & 255;
        dutyLog.push_back(w);
      end
      5: mOn = data & 255;
      6: mOff = data & 255;
      default: ;
    endcase
    stepCycle();
    wr_en = 1'b0;
  endtask

  // Two reset cycles with a CTRL write pending that must be discarded.
  task automatic doReset();
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'd1;
    sessStart = -1;
    sessStop  = -1;
    mPre = 0;
    mOn  = 0;
    mOff = 0;
    dutyLog.delete();
    runCycles(2);
    rst   = 1'b0;
    wr_en = 1'b0;
  endtask

  function automatic int pickDuty();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 255;
      2: return 1;
      3: return 254;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int onEdge, fl, blinkSel;
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = 3'd0;
    wr_data = 8'd0;

    doReset();
    runCycles(20);

    applyStimulus(1, 0);
    applyStimulus(2, 64);
    applyStimulus(3, 0);
    applyStimulus(4, 255);
    applyStimulus(0, 1);
    onEdge = sessStart + W + 1;
    runUntil(sessStart + W);
    checkOutput("warm_curren", 32'(curren), 32'd1);
    checkOutput("warm_ready_low", 32'(ready), 32'd0);
    runUntil(onEdge);
    checkOutput("warm_ready_high", 32'(ready), 32'd1);
    runUntil(onEdge + 256 + 100);
    applyStimulus(2, 200);
    runUntil(onEdge + 3 * 256 + 2);
    checkOutput("f0_rgb0", frameHigh[0][0], 64);
    checkOutput("f0_rgb1", frameHigh[1][0], 0);
    checkOutput("f0_rgb2", frameHigh[2][0], 255);
    checkOutput("f1_rgb0_keeps", frameHigh[0][1], 64);
    checkOutput("f2_rgb0_new", frameHigh[0][2], 200);
    checkOutput("f2_rgb2", frameHigh[2][2], 255);
    applyStimulus(0, 0);
    runCycles(10);

    applyStimulus(5, 2);
    applyStimulus(6, 3);
    applyStimulus(0, 3);
    onEdge = sessStart + W + 1;
    runUntil(onEdge + 7 * 256 + 2);
    for (int f = 0; f < 7; f++) begin
      checkOutput($sformatf("blink_f%0d", f), frameHigh[0][f], ((f % 5) < 2) ? 200 : 0);
    end
    applyStimulus(0, 0);
    stepCycle();
    checkOutput("disable_all_low",
                32'({ready, curren, rgbleden, rgb2_pwm, rgb1_pwm, rgb0_pwm}), 32'd0);
    runCycles(5);
    applyStimulus(0, 1);
    runUntil(sessStart + W);
    checkOutput("rewarm_ready_low", 32'(ready), 32'd0);
    runUntil(sessStart + W + 1);
    checkOutput("rewarm_ready_high", 32'(ready), 32'd1);
    applyStimulus(0, 0);
    runCycles(4);

    for (int s = 0; s < 5; s++) begin
      applyStimulus(1, int'($urandom_range(0, 2)));
      applyStimulus(5, int'($urandom_range(0, 3)));
      applyStimulus(6, int'($urandom_range(0, 3)));
      for (int ch = 0; ch < 3; ch++) applyStimulus(2 + ch, pickDuty());
      if ($urandom_range(0, 1) == 1) applyStimulus(7, int'($urandom_range(0, 255)));
      blinkSel = int'($urandom_range(0, 1));
      applyStimulus(0, (blinkSel == 1) ? 3 : 1);
      onEdge = sessStart + W + 1;
      fl = 256 * (sessPre + 1);
      runUntil(onEdge + 2 * fl - 1);
      applyStimulus(2 + int'($urandom_range(0, 2)), pickDuty());
      runUntil(onEdge + 3 * fl - 2);
      applyStimulus(2 + int'($urandom_range(0, 2)), pickDuty());
      runUntil(onEdge + 3 * fl + int'($urandom_range(1, 200)));
      applyStimulus(2 + int'($urandom_range(0, 2)), pickDuty());
      runUntil(onEdge + 5 * fl + int'($urandom_range(0, 255)));
      applyStimulus(0, 0);
      runCycles(int'($urandom_range(1, 20)));
    end

    applyStimulus(0, 1);
    runUntil(sessStart + W + 300);
    doReset();
    runCycles(5);
    checkOutput("post_reset_low",
                32'({ready, curren, rgbleden, rgb2_pwm, rgb1_pwm, rgb0_pwm}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
